// File: rtl/handshake_protocol_monitor.sv
// Passive ready/valid protocol checker for NUM_CH independent channels.
// Produces sticky per-channel error flags and saturating handshake counters.
module handshake_protocol_monitor #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 16,
  parameter int MAX_STALL  = 15,
  parameter int CHECK_DATA = 1
) (
  input  logic                       CLK,
  input  logic                       ASYNCRESETN,
  input  logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH-1:0]          ch_ready,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  input  logic                       clr,
  output logic [NUM_CH-1:0]          err_valid_drop,
  output logic [NUM_CH-1:0]          err_data_chg,
  output logic [NUM_CH-1:0]          err_stall,
  output logic                       err_any,
  output logic [NUM_CH*CNT_W-1:0]    xfer_cnt
);

  localparam int             SW        = $clog2(MAX_STALL + 1);
  localparam logic [SW-1:0]  STALL_LIM = SW'(MAX_STALL);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam bit             DATA_ON   = (CHECK_DATA != 0);

  // History of the previous edge, used to judge the current one.
  logic [NUM_CH-1:0]              pend_q, pend_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  data_q, data_d;
  logic [NUM_CH-1:0][SW-1:0]      stall_q, stall_d;

  logic [NUM_CH-1:0]              drop_q, drop_d;
  logic [NUM_CH-1:0]              chg_q, chg_d;
  logic [NUM_CH-1:0]              tmo_q, tmo_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   xfer_q, xfer_d;

  logic [NUM_CH-1:0] stalled;
  logic [NUM_CH-1:0] handshake;
  logic [NUM_CH-1:0] drop_hit;
  logic [NUM_CH-1:0] chg_hit;
  logic [NUM_CH-1:0] tmo_hit;

  assign stalled   = ch_valid & ~ch_ready;
  assign handshake = ch_valid & ch_ready;
  assign drop_hit  = pend_q & ~ch_valid;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    chg_hit = '0;
    data_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      data_d[i]  = ch_data[i*DATA_W +: DATA_W];
      chg_hit[i] = DATA_ON && pend_q[i] && ch_valid[i] && (data_d[i] != data_q[i]);
    end
  end

  // Stall counter saturates; the flag fires only on the edge that reaches the limit.
  always_comb begin
    stall_d = '0;
    tmo_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (stalled[i]) begin
        stall_d[i] = (stall_q[i] == STALL_LIM) ? STALL_LIM : stall_q[i] + SW'(1);
        tmo_hit[i] = (stall_q[i] == STALL_LIM - SW'(1));
      end
    end
  end

  // clr wipes the old value first, so a same-edge set or handshake still lands.
  always_comb begin
    pend_d = stalled;
    drop_d = (clr ? '0 : drop_q) | drop_hit;
    chg_d  = (clr ? '0 : chg_q)  | chg_hit;
    tmo_d  = (clr ? '0 : tmo_q)  | tmo_hit;
    xfer_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      xfer_d[i] = clr ? '0 : xfer_q[i];
      if (handshake[i] && (xfer_d[i] != CNT_MAX)) begin
        xfer_d[i] = xfer_d[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      // NOTE: history registers are reset too, so a stall cut short by reset cannot flag on release.
      pend_q  <= '0;
      data_q  <= '0;
      stall_q <= '0;
      drop_q  <= '0;
      chg_q   <= '0;
      tmo_q   <= '0;
      xfer_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      pend_q  <= pend_d;
      data_q  <= data_d;
      stall_q <= stall_d;
      drop_q  <= drop_d;
      chg_q   <= chg_d;
      tmo_q   <= tmo_d;
      xfer_q  <= xfer_d;
    end
  end

  assign err_valid_drop = drop_q;
  assign err_data_chg   = chg_q;
  assign err_stall      = tmo_q;
  assign err_any        = |{drop_q, chg_q, tmo_q};

  always_comb begin
    xfer_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      xfer_cnt[i*CNT_W +: CNT_W] = xfer_q[i];
    end
  end

endmodule

// File: tb/tb_handshake_protocol_monitor.sv
// Scoreboard bench: stimulus queues expected outputs, a monitor process compares them.
// A second instance (CNT_W=2, CHECK_DATA=0) shares the stimulus for saturation and data-off cases.
module tb_handshake_protocol_monitor;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;

  logic                     CLK = 1'b0;
  logic                     ASYNCRESETN;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_ready;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     clr;

  logic [NUM_CH-1:0]        a_evd, a_edc, a_est;
  logic                     a_any;
  logic [NUM_CH*16-1:0]     a_xfer;
  logic [NUM_CH-1:0]        b_evd, b_edc, b_est;
  logic                     b_any;
  logic [NUM_CH*2-1:0]      b_xfer;

  always #5 CLK = ~CLK;

  handshake_protocol_monitor #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(16), .MAX_STALL(15), .CHECK_DATA(1)
  ) dut_a (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data), .clr(clr),
    .err_valid_drop(a_evd), .err_data_chg(a_edc), .err_stall(a_est),
    .err_any(a_any), .xfer_cnt(a_xfer)
  );

  handshake_protocol_monitor #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(2), .MAX_STALL(15), .CHECK_DATA(0)
  ) dut_b (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data), .clr(clr),
    .err_valid_drop(b_evd), .err_data_chg(b_edc), .err_stall(b_est),
    .err_any(b_any), .xfer_cnt(b_xfer)
  );

  typedef enum int {
    S_EVD, S_EDC, S_EST, S_ANY, S_X0, S_X1, S_X2, S_X3,
    S_BX0, S_BEVD, S_BEDC, S_BEST, S_BANY
  } sel_e;

  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  event chk_ev;

  function automatic logic [31:0] read_sig(sel_e s);
    logic [31:0] r;
    r = '0;
    case (s)
      S_EVD:  r[3:0]  = a_evd;
      S_EDC:  r[3:0]  = a_edc;
      S_EST:  r[3:0]  = a_est;
      S_ANY:  r[0]    = a_any;
      S_X0:   r[15:0] = a_xfer[15:0];
      S_X1:   r[15:0] = a_xfer[31:16];
      S_X2:   r[15:0] = a_xfer[47:32];
      S_X3:   r[15:0] = a_xfer[63:48];
      S_BX0:  r[1:0]  = b_xfer[1:0];
      S_BEVD: r[3:0]  = b_evd;
      S_BEDC: r[3:0]  = b_edc;
      S_BEST: r[3:0]  = b_est;
      S_BANY: r[0]    = b_any;
      default: r = '1;
    endcase
    return r;
  endfunction

  // Monitor: drains the scoreboard at every falling edge or on explicit request.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge CLK or chk_ev);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = read_sig(e.sel);
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s (%s): got 0x%0h, expected 0x%0h", e.name, e.sel.name(), act, e.exp);
        end
      end
    end
  end

  task automatic push(string name, sel_e sel, logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic exp_a(string name, logic [3:0] evd, logic [3:0] edc, logic [3:0] est);
    push(name, S_EVD, 32'(evd));
    push(name, S_EDC, 32'(edc));
    push(name, S_EST, 32'(est));
    push(name, S_ANY, 32'(|{evd, edc, est}));
  endtask

  task automatic exp_b(string name, logic [3:0] evd, logic [3:0] edc, logic [3:0] est);
    push(name, S_BEVD, 32'(evd));
    push(name, S_BEDC, 32'(edc));
    push(name, S_BEST, 32'(est));
    push(name, S_BANY, 32'(|{evd, edc, est}));
  endtask

  task automatic drive(int ch, logic v, logic r, logic [7:0] d);
    ch_valid[ch]                = v;
    ch_ready[ch]                = r;
    ch_data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic step(int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ASYNCRESETN = 1'b0;
    ch_valid    = '0;
    ch_ready    = '0;
    ch_data     = '0;
    clr         = 1'b0;
    repeat (3) @(posedge CLK);
    #1 ASYNCRESETN = 1'b1;

    // Reset state, first edge after release
    step();
    exp_a("reset", 4'b0000, 4'b0000, 4'b0000);
    exp_b("reset_b", 4'b0000, 4'b0000, 4'b0000);
    push("reset_x0", S_X0, 0);
    push("reset_x1", S_X1, 0);
    push("reset_x2", S_X2, 0);
    push("reset_x3", S_X3, 0);
    push("reset_bx0", S_BX0, 0);

    // T1: legal stall with stable data, then one handshake
    drive(0, 1, 0, 8'hA5);
    step(3);
    exp_a("t1_stall", 4'b0000, 4'b0000, 4'b0000);
    drive(0, 1, 1, 8'hA5);
    step();
    exp_a("t1_xfer", 4'b0000, 4'b0000, 4'b0000);
    push("t1_x0", S_X0, 1);
    push("t1_bx0", S_BX0, 1);
    drive(0, 0, 0, 8'h00);
    step();

    // T2: valid dropped before handshake
    drive(1, 1, 0, 8'h11);
    step();
    exp_a("t2_pending", 4'b0000, 4'b0000, 4'b0000);
    drive(1, 0, 0, 8'h00);
    step();
    exp_a("t2_drop", 4'b0010, 4'b0000, 4'b0000);
    exp_b("t2_drop_b", 4'b0010, 4'b0000, 4'b0000);
    step(2);
    exp_a("t2_hold", 4'b0010, 4'b0000, 4'b0000);
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_a("t2_clr", 4'b0000, 4'b0000, 4'b0000);

    // T3: payload changes while stalled; instance b has the check disabled
    drive(2, 1, 0, 8'h3C);
    step();
    drive(2, 1, 0, 8'h3D);
    step();
    exp_a("t3_chg", 4'b0000, 4'b0100, 4'b0000);
    exp_b("t3_chg_off", 4'b0000, 4'b0000, 4'b0000);
    drive(2, 1, 1, 8'h3D);
    step();
    push("t3_x2", S_X2, 1);
    drive(2, 0, 0, 8'h00);
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_a("t3_clr", 4'b0000, 4'b0000, 4'b0000);

    // T4: stall timeout boundary at 14/15 edges
    drive(3, 1, 0, 8'h77);
    step(14);
    exp_a("t4_14", 4'b0000, 4'b0000, 4'b0000);
    drive(3, 1, 1, 8'h77);
    step();
    exp_a("t4_14_xfer", 4'b0000, 4'b0000, 4'b0000);
    push("t4_x3a", S_X3, 1);
    drive(3, 1, 0, 8'h77);
    step(14);
    exp_a("t4_cnt_zeroed", 4'b0000, 4'b0000, 4'b0000);
    step();
    exp_a("t4_15", 4'b0000, 4'b0000, 4'b1000);
    exp_b("t4_15_b", 4'b0000, 4'b0000, 4'b1000);
    step(5);
    exp_a("t4_sticky", 4'b0000, 4'b0000, 4'b1000);
    drive(3, 1, 1, 8'h77);
    step();
    push("t4_x3b", S_X3, 2);
    drive(3, 0, 0, 8'h00);
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_a("t4_clr", 4'b0000, 4'b0000, 4'b0000);
    push("t4_clr_x3", S_X3, 0);

    // T5: saturation on the 2-bit counter, clr interplay
    drive(0, 1, 1, 8'h01);
    step(5);
    push("t5_x0", S_X0, 5);
    push("t5_bx0_sat", S_BX0, 3);
    clr = 1'b1;
    step();
    clr = 1'b0;
    push("t5_clr_xfer", S_X0, 1);
    push("t5_clr_bxfer", S_BX0, 1);
    drive(0, 0, 0, 8'h00);
    drive(1, 1, 0, 8'h22);
    step();
    drive(1, 0, 0, 8'h00);
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_a("t5_clr_set", 4'b0010, 4'b0000, 4'b0000);
    exp_b("t5_clr_set_b", 4'b0010, 4'b0000, 4'b0000);

    // T6: asynchronous reset in the middle of a stall
    drive(3, 1, 0, 8'h55);
    step(2);
    #1 ASYNCRESETN = 1'b0;
    #1;
    exp_a("t6_async", 4'b0000, 4'b0000, 4'b0000);
    exp_b("t6_async_b", 4'b0000, 4'b0000, 4'b0000);
    push("t6_x0", S_X0, 0);
    push("t6_x3", S_X3, 0);
    push("t6_bx0", S_BX0, 0);
    -> chk_ev;
    drive(3, 0, 0, 8'h00);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    step();
    exp_a("t6_release", 4'b0000, 4'b0000, 4'b0000);
    exp_b("t6_release_b", 4'b0000, 4'b0000, 4'b0000);

    @(negedge CLK);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
